// File: rtl/fft_out_serializer.sv
// fft_out_serializer
// Drains the bit-reversal stage's burst output into a two-bank ping-pong
// frame buffer and replays each frame one complex sample per cycle on a
// valid/ready stream. A frame arrives as BEATS wide beats of LANES samples
// each. It leaves as POINTS single samples tagged with the bin index and with
// first/last markers. The data passes through bit-exact.
module fft_out_serializer #(
  parameter  int WIDTH  = 13,
  parameter  int LANES  = 16,
  parameter  int POINTS = 512,
  localparam int IDXW   = $clog2(POINTS)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         din_en,
  input  logic [LANES-1:0][WIDTH-1:0]  din_re,
  input  logic [LANES-1:0][WIDTH-1:0]  din_im,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [WIDTH-1:0]             m_re,
  output logic [WIDTH-1:0]             m_im,
  output logic [IDXW-1:0]              m_idx,
  output logic                         m_first,
  output logic                         m_last,
  output logic                         ovf,
  output logic                         frame_err
);

  localparam int BEATS = POINTS / LANES;
  localparam int BW    = $clog2(BEATS);
  localparam int LW    = $clog2(LANES);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

  // Frame storage: one wide word per beat, indexed [bank][beat].
  logic [LANES-1:0][WIDTH-1:0] mem_re_r [0:1][0:BEATS-1];
  logic [LANES-1:0][WIDTH-1:0] mem_im_r [0:1][0:BEATS-1];

  // Bank bookkeeping.
  logic [1:0]      full_r, full_nxt_s;
  logic            wr_bank_r, wr_bank_nxt_s;
  logic            rd_bank_r, rd_bank_nxt_s;

  // Write-side state.
  logic [BW-1:0]   wbeat_r, wbeat_nxt_s;
  logic            drop_r, drop_nxt_s;
  logic            store_s;
  logic            set_full_s;
  logic            ovf_nxt_s;
  logic            ferr_nxt_s;

  // Read-side state.
  rd_state_t       state_r, state_nxt_s;
  logic            load_s;
  logic            load_bank_s;
  logic [IDXW-1:0] load_idx_s;
  logic            clr_full_s;
  logic            valid_nxt_s;
  logic [WIDTH-1:0] rd_re_s, rd_im_s;

  // Output registers.
  logic            m_valid_r;
  logic [WIDTH-1:0] m_re_r, m_im_r;
  logic [IDXW-1:0] m_idx_r;
  logic            m_first_r, m_last_r;
  logic            ovf_r, frame_err_r;

  assign m_valid   = m_valid_r;
  assign m_re      = m_re_r;
  assign m_im      = m_im_r;
  assign m_idx     = m_idx_r;
  assign m_first   = m_first_r;
  assign m_last    = m_last_r;
  assign ovf       = ovf_r;
  assign frame_err = frame_err_r;

  // Write side: beat counting, drop decision at beat 0, frame completion and error detection.
  always_comb begin
    wbeat_nxt_s   = wbeat_r;
    drop_nxt_s    = drop_r;
    store_s       = 1'b0;
    set_full_s    = 1'b0;
    ovf_nxt_s     = 1'b0;
    ferr_nxt_s    = 1'b0;
    wr_bank_nxt_s = wr_bank_r;
    if (din_en) begin
      if (wbeat_r == {BW{1'b0}}) begin
        // The target bank is judged by its registered flag, so a bank freed
        // in this very cycle still counts as full.
        if (full_r[wr_bank_r]) begin
          ovf_nxt_s  = 1'b1;
          drop_nxt_s = 1'b1;
        end else begin
          store_s    = 1'b1;
          drop_nxt_s = 1'b0;
        end
      end else begin
        store_s = ~drop_r;
      end
      if (wbeat_r == BW'(BEATS-1)) begin
        // A dropped frame still runs its full length so that a following
        // frame can start back-to-back.
        wbeat_nxt_s = {BW{1'b0}};
        drop_nxt_s  = 1'b0;
        if (!drop_r) begin
          set_full_s    = 1'b1;
          wr_bank_nxt_s = ~wr_bank_r;
        end else begin
          set_full_s    = 1'b0;
        end
      end else begin
        wbeat_nxt_s = wbeat_r + BW'(1);
      end
    end else begin
      if (wbeat_r != {BW{1'b0}}) begin
        ferr_nxt_s = 1'b1;
      end else begin
        ferr_nxt_s = 1'b0;
      end
      wbeat_nxt_s = {BW{1'b0}};
      drop_nxt_s  = 1'b0;
    end
  end

  // Read FSM: pick which sample to load into the output register and when a bank is released.
  always_comb begin
    state_nxt_s   = state_r;
    load_s        = 1'b0;
    load_bank_s   = rd_bank_r;
    load_idx_s    = {IDXW{1'b0}};
    clr_full_s    = 1'b0;
    rd_bank_nxt_s = rd_bank_r;
    valid_nxt_s   = m_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (full_r[rd_bank_r]) begin
          load_s      = 1'b1;
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_STREAM;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      ST_STREAM: begin
        if (m_valid_r && m_ready) begin
          if (m_idx_r == IDXW'(POINTS-1)) begin
            clr_full_s    = 1'b1;
            rd_bank_nxt_s = ~rd_bank_r;
            if (full_r[~rd_bank_r]) begin
              // Next frame already waiting: continue without a bubble.
              load_s      = 1'b1;
              load_bank_s = ~rd_bank_r;
            end else begin
              valid_nxt_s = 1'b0;
              state_nxt_s = ST_IDLE;
            end
          end else begin
            load_s     = 1'b1;
            load_idx_s = m_idx_r + IDXW'(1);
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Full flags: set and clear act on different banks and both take effect.
  always_comb begin
    full_nxt_s = full_r;
    if (set_full_s) begin
      full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
    end
    if (clr_full_s) begin
      full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
    end
  end

  // Sample fetch: beat word selected by the upper index bits, lane by the lower bits.
  always_comb begin
    rd_re_s = mem_re_r[load_bank_s][load_idx_s[IDXW-1:LW]][load_idx_s[LW-1:0]];
    rd_im_s = mem_im_r[load_bank_s][load_idx_s[IDXW-1:LW]][load_idx_s[LW-1:0]];
  end

  // Buffer write: all lanes of a beat land in one cycle, no reset needed on contents.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_re_r[wr_bank_r][wbeat_r] <= din_re;
      mem_im_r[wr_bank_r][wbeat_r] <= din_im;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_r      <= 2'b00;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      wbeat_r     <= {BW{1'b0}};
      drop_r      <= 1'b0;
      state_r     <= ST_IDLE;
      ovf_r       <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      full_r      <= full_nxt_s;
      wr_bank_r   <= wr_bank_nxt_s;
      rd_bank_r   <= rd_bank_nxt_s;
      wbeat_r     <= wbeat_nxt_s;
      drop_r      <= drop_nxt_s;
      state_r     <= state_nxt_s;
      ovf_r       <= ovf_nxt_s;
      frame_err_r <= ferr_nxt_s;
    end
  end

  // Output register: loads a new sample on demand and otherwise holds while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_r <= 1'b0;
      m_re_r    <= {WIDTH{1'b0}};
      m_im_r    <= {WIDTH{1'b0}};
      m_idx_r   <= {IDXW{1'b0}};
      m_first_r <= 1'b0;
      m_last_r  <= 1'b0;
    end else begin
      m_valid_r <= valid_nxt_s;
      if (load_s) begin
        m_re_r    <= rd_re_s;
        m_im_r    <= rd_im_s;
        m_idx_r   <= load_idx_s;
        m_first_r <= (load_idx_s == {IDXW{1'b0}});
        m_last_r  <= (load_idx_s == IDXW'(POINTS-1));
      end
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Testbench for fft_out_serializer: randomized stimulus against a frame-level
// model (queues of whole frames and their availability times), compared every
// cycle on the falling edge, plus literal checks of latency and counts.
module tb_fft_out_serializer;
  localparam int WIDTH  = 13;
  localparam int LANES  = 16;
  localparam int POINTS = 512;
  localparam int BEATS  = POINTS / LANES;
  localparam int IDXW   = 9;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din_en = 1'b0;
  logic m_ready = 1'b0;
  logic [LANES-1:0][WIDTH-1:0] din_re = '0;
  logic [LANES-1:0][WIDTH-1:0] din_im = '0;
  logic m_valid, m_first, m_last, ovf, frame_err;
  logic [WIDTH-1:0] m_re, m_im;
  logic [IDXW-1:0] m_idx;

  always #5 clk = ~clk;

  fft_out_serializer #(.WIDTH(WIDTH), .LANES(LANES), .POINTS(POINTS)) dut (
    .clk(clk), .rstn(rstn), .din_en(din_en), .din_re(din_re), .din_im(din_im),
    .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_idx(m_idx),
    .m_first(m_first), .m_last(m_last), .ovf(ovf), .frame_err(frame_err)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  // Model state: stored frames as flat sample queues plus per-frame ready time.
  logic [WIDTH-1:0] exp_re_q[$];
  logic [WIDTH-1:0] exp_im_q[$];
  int fav_q[$];
  int rptr = 0;
  int wcnt = 0;
  bit dropping = 0;
  bit exp_ovf = 0;
  bit exp_ferr = 0;
  logic [WIDTH-1:0] cur_re [POINTS];
  logic [WIDTH-1:0] cur_im [POINTS];

  // Observed statistics for literal checks.
  int n_acc, n_ovf, n_ferr, n_first, n_last, run, max_run, beat0_cyc, rise_cyc;
  logic [WIDTH-1:0] cap_re, cap_im;
  bit prev_v = 0;
  int ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    n_acc = 0; n_ovf = 0; n_ferr = 0; n_first = 0; n_last = 0;
    max_run = 0; beat0_cyc = -1; rise_cyc = -1;
  endtask

  // Compare process: check outputs against the model, then advance the model.
  always @(negedge clk) begin
    bit exp_v;
    cyc++;
    if (!rstn) begin
      exp_re_q.delete(); exp_im_q.delete(); fav_q.delete();
      rptr = 0; wcnt = 0; dropping = 0; exp_ovf = 0; exp_ferr = 0;
      prev_v = 0; run = 0;
    end else begin
      exp_v = (fav_q.size() > 0) && (fav_q[0] <= cyc);
      chk("m_valid", m_valid, exp_v);
      if (exp_v && m_valid) begin
        chk("m_re", m_re, exp_re_q[0]);
        chk("m_im", m_im, exp_im_q[0]);
        chk("m_idx", m_idx, rptr);
        chk("m_first", m_first, rptr == 0);
        chk("m_last", m_last, rptr == POINTS-1);
      end
      chk("ovf", ovf, exp_ovf);
      chk("frame_err", frame_err, exp_ferr);
      if (ovf) n_ovf++;
      if (frame_err) n_ferr++;
      if (m_valid && !prev_v) rise_cyc = cyc;
      prev_v = m_valid;
      if (m_valid) run++; else run = 0;
      if (run > max_run) max_run = run;

      // Writer: a frame is dropped when both banks hold undrained frames.
      exp_ovf = 0; exp_ferr = 0;
      if (din_en) begin
        if (wcnt == 0) begin
          beat0_cyc = cyc;
          if (fav_q.size() == 2) begin exp_ovf = 1; dropping = 1; end
          else dropping = 0;
        end
        if (!dropping)
          for (int i = 0; i < LANES; i++) begin
            cur_re[wcnt*LANES+i] = din_re[i];
            cur_im[wcnt*LANES+i] = din_im[i];
          end
        if (wcnt == BEATS-1) begin
          if (!dropping) begin
            for (int k = 0; k < POINTS; k++) begin
              exp_re_q.push_back(cur_re[k]);
              exp_im_q.push_back(cur_im[k]);
            end
            fav_q.push_back(cyc + 2);
          end
          wcnt = 0; dropping = 0;
        end else wcnt++;
      end else if (wcnt != 0) begin
        exp_ferr = 1; wcnt = 0; dropping = 0;
      end

      // Reader: one sample leaves per accepted cycle.
      if (exp_v && m_ready) begin
        if (rptr == 5) begin cap_re = exp_re_q[0]; cap_im = exp_im_q[0]; end
        if (m_first) n_first++;
        if (m_last) n_last++;
        void'(exp_re_q.pop_front());
        void'(exp_im_q.pop_front());
        n_acc++;
        rptr++;
        if (rptr == POINTS) begin rptr = 0; void'(fav_q.pop_front()); end
      end
    end
  end

  // Consumer readiness: always, random 50%, or never.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  task automatic beat(input int kind, input int base, input int b);
    int k;
    @(posedge clk); #1;
    din_en = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      k = b*LANES + i;
      if (kind == 0) begin
        din_re[i] = WIDTH'(base + k);
        din_im[i] = WIDTH'(-k);
      end else begin
        din_re[i] = WIDTH'($urandom);
        din_im[i] = WIDTH'($urandom);
      end
    end
  endtask

  task automatic frame(input int kind, input int base);
    for (int b = 0; b < BEATS; b++) beat(kind, base, b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; din_en = 1'b0; end
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int c = 0;
    while ((fav_q.size() != 0 || m_valid) && c < maxc) begin
      @(posedge clk); #1; c++;
    end
    if (c >= maxc) begin
      nvec++; nerr++;
      $display("FAIL %s: drain timeout after %0d cycles, %0d frames left", name, c, fav_q.size());
    end
    idle(3);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; din_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int c;
    clr_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_re", m_re, 0);
    chk("rst_m_im", m_im, 0);
    chk("rst_m_idx", m_idx, 0);
    chk("rst_flags", {m_first, m_last, ovf, frame_err}, 0);
    rstn = 1'b1;

    // Single frame, always ready.
    ready_mode = 0; idle(2); clr_stats();
    frame(0, 0); idle(1); wait_drain("t1", 3000);
    chk("t1_latency", rise_cyc - beat0_cyc, 33);
    chk("t1_count", n_acc, 512);
    chk("t1_first", n_first, 1);
    chk("t1_last", n_last, 1);
    chk("t1_bin5_re", cap_re, 5);
    chk("t1_bin5_im", cap_im, 13'h1FFB);

    // Same frame, random back-pressure.
    ready_mode = 1; clr_stats();
    frame(0, 0); idle(1); wait_drain("t2", 6000);
    chk("t2_count", n_acc, 512);
    chk("t2_first", n_first, 1);
    chk("t2_last", n_last, 1);

    // Two frames back-to-back, no bubble between them.
    ready_mode = 0; idle(2); clr_stats();
    frame(0, 0); frame(0, 1000); idle(1); wait_drain("t3", 4000);
    chk("t3_run", max_run, 1024);
    chk("t3_count", n_acc, 1024);

    // Three frames back-to-back while stalled: the third is dropped.
    ready_mode = 2; idle(2); clr_stats();
    frame(0, 0); frame(0, 1000); frame(0, 2000); idle(4);
    chk("t4_ovf", n_ovf, 1);
    chk("t4_ferr", n_ferr, 0);
    ready_mode = 0; wait_drain("t4", 4000);
    chk("t4_count", n_acc, 1024);

    // Truncated frame, then a good one after a clean reset.
    do_reset(); clr_stats();
    for (int b = 0; b < 10; b++) beat(0, 0, b);
    idle(40);
    chk("t5_ferr", n_ferr, 1);
    chk("t5_no_out", n_acc, 0);
    frame(0, 500); idle(1); wait_drain("t5", 3000);
    chk("t5_count", n_acc, 512);

    // Reset in the middle of streaming.
    clr_stats();
    frame(0, 0); idle(1);
    c = 0;
    while (!(m_valid && m_idx == 9'd200) && c < 2000) begin @(posedge clk); #1; c++; end
    chk("t6_reach_200", c < 2000, 1);
    rstn = 1'b0;
    #1;
    chk("t6_m_valid", m_valid, 0);
    chk("t6_m_re", m_re, 0);
    chk("t6_m_im", m_im, 0);
    chk("t6_m_idx", m_idx, 0);
    chk("t6_flags", {m_first, m_last, ovf, frame_err}, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle(2); clr_stats();
    frame(1, 0); idle(1); wait_drain("t6", 3000);
    chk("t6_count", n_acc, 512);
    chk("t6_first", n_first, 1);

    // Random data, random gaps, random back-pressure, one aborted frame.
    ready_mode = 1; clr_stats();
    for (int f = 0; f < 5; f++) begin
      if (f == 2) begin
        for (int b = 0; b < 5; b++) beat(1, 0, b);
        idle(1);
      end
      frame(1, 0);
      idle($urandom_range(0, 3));
    end
    idle(1); wait_drain("t7", 20000);
    chk("t7_ferr", n_ferr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
